// File: rtl/mem_copy_dma.sv
// ---------------------------------------------------------------------------
// mem_copy_dma
//
// Purpose:
//   Word-copy DMA engine that takes the initiator side of the single-port
//   data memory. It copies a block of 32-bit words in ascending order from a
//   source byte address to a destination byte address. It uses the same
//   memory interface the processor drives: combinational read data, and a
//   write on the rising clock edge while mem_we is high. An external mux
//   hands the port to this engine whenever gnt is high.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   start      in   one-cycle copy request, honoured only while idle
//   src_addr   in   byte address of the first source word
//   dst_addr   in   byte address of the first destination word
//   length     in   number of words to copy (0 completes immediately)
//   gnt        in   memory port belongs to the DMA this cycle
//   busy       out  transfer in progress (READ, WRITE, FIN)
//   done       out  one-cycle completion pulse
//   err        out  one-cycle pulse: request rejected, address misaligned
//   mem_addr   out  byte address to data memory
//   mem_wdata  out  write data to data memory
//   mem_we     out  write enable to data memory, always gated by gnt
//   mem_rdata  in   combinational read data from data memory
// ---------------------------------------------------------------------------
module mem_copy_dma #(
    parameter int LEN_W     = 7,
    parameter int ADDR_STEP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
    input  logic             gnt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_we,
    input  logic [31:0]      mem_rdata
);

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t           state_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [31:0]      data_q;
    logic [LEN_W-1:0] count_q;
    logic             err_q;

    logic [31:0]      src_d;
    logic [31:0]      dst_d;
    logic [LEN_W-1:0] count_d;
    logic             misaligned;
    logic             last_word;

    // Pointer arithmetic is plain 32-bit and wraps modulo 2^32, so a block
    // starting at the top of the address space continues at address zero.
    assign src_d   = src_q + STEP;
    assign dst_d   = dst_q + STEP;
    assign count_d = count_q - LEN_W'(1);

    // A request is refused when either pointer is not word aligned.
    assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

    // The write that retires the word with count 1 is the final one.
    assign last_word  = (count_q == LEN_W'(1));

    // Control FSM and datapath registers. A READ or WRITE only advances in a
    // cycle where the port is granted; otherwise every register holds, so a
    // stalled transfer resumes exactly where it stopped. Reset abandons any
    // transfer in flight without undoing the words already written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (misaligned) begin
                            err_q <= 1'b1;
                        end else if (length == '0) begin
                            state_q <= FIN;
                        end else begin
                            src_q   <= src_addr;
                            dst_q   <= dst_addr;
                            count_q <= length;
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (gnt) begin
                        data_q  <= mem_rdata;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (gnt) begin
                        src_q   <= src_d;
                        dst_q   <= dst_d;
                        count_q <= count_d;
                        state_q <= last_word ? FIN : READ;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Status outputs are decoded straight from registered state, so they are
    // glitch-free and done/err can never coincide (err only fires from IDLE).
    assign busy = (state_q != IDLE);
    assign done = (state_q == FIN);
    assign err  = err_q;

    // The write enable is gated by gnt combinationally so the DMA never writes
    // while the processor owns the port. Because it is decoded from state, an
    // asynchronous reset drops it immediately without waiting for a clock.
    assign mem_we    = (state_q == WRITE) && gnt;
    assign mem_wdata = data_q;

    // The address tracks the source pointer while reading and the destination
    // pointer while writing; it rests at zero otherwise.
    always_comb begin
        mem_addr = '0;
        case (state_q)
            READ:    mem_addr = src_q;
            WRITE:   mem_addr = dst_q;
            default: mem_addr = '0;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// ---------------------------------------------------------------------------
// tb_mem_copy_dma
//
// Purpose:
//   Directed self-checking bench for mem_copy_dma. A 64-word RAM model sits
//   on the memory port (word index = address bits [7:2]); every expected
//   value below is hand-computed from the intended copy behaviour.
// ---------------------------------------------------------------------------
module tb_mem_copy_dma;

    localparam int LEN_W = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] length;
    logic             gnt;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_we;
    logic [31:0]      mem_rdata;

    logic [31:0] ram [0:63];
    logic [31:0] wrAddr [$];
    int          wrCount = 0;
    int          checks  = 0;
    int          errors  = 0;

    mem_copy_dma #(.LEN_W(LEN_W), .ADDR_STEP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read, write on the rising edge with mem_we.
    assign mem_rdata = ram[mem_addr[7:2]];

    // Commit writes into the RAM model and log every write address.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[7:2]] = mem_wdata;
            wrCount++;
            wrAddr.push_back(mem_addr);
        end
    end

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fill the RAM with a recognisable background pattern.
    task automatic clearRam();
        for (int i = 0; i < 64; i++) ram[i] = 32'hDEAD0000 | 32'(i);
        wrAddr.delete();
    endtask

    // Pulse start for one edge with the given request; returns in cycle 1.
    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input int len);
        src_addr = src;
        dst_addr = dst;
        length   = LEN_W'(len);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Step until busy drops, recording busy length, done cycle, writes issued
    // without grant and err pulses. Optionally toggles gnt 1,0,1,0...
    task automatic waitIdle(input bit toggle, input int limit,
                            output int busyCycles, output int doneCycle,
                            output int weViol, output int errSeen);
        bit finished;
        finished   = 1'b0;
        busyCycles = 0;
        doneCycle  = 0;
        weViol     = 0;
        errSeen    = 0;
        for (int k = 1; k <= limit; k++) begin
            gnt = (toggle && (k % 2 == 0)) ? 1'b0 : 1'b1;
            #1;
            if (mem_we && !gnt) weViol++;
            if (err) errSeen++;
            if (done && doneCycle == 0) doneCycle = k;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            busyCycles++;
            tick();
        end
        if (!finished) checkOutput("timeout", 32'd0, 32'd1);
        gnt = 1'b1;
    endtask

    int busyN, doneN, weV, errN, wr0;

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        gnt      = 1'b1;
        clearRam();

        // Reset state
        #12;
        checkOutput("rst_busy",  32'(busy), 32'd0);
        checkOutput("rst_done",  32'(done), 32'd0);
        checkOutput("rst_err",   32'(err), 32'd0);
        checkOutput("rst_we",    32'(mem_we), 32'd0);
        checkOutput("rst_addr",  mem_addr, 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b1;
        tick();

        // Basic copy of 4 words, gnt held high
        $display("[TB] basic copy");
        clearRam();
        ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[3] = 32'h44;
        wr0 = wrCount;
        applyStimulus(32'h00, 32'h40, 4);
        checkOutput("basic_rd_addr", mem_addr, 32'h00);
        waitIdle(1'b0, 50, busyN, doneN, weV, errN);
        checkOutput("basic_busy_len", 32'(busyN), 32'd9);
        checkOutput("basic_done_cyc", 32'(doneN), 32'd9);
        checkOutput("basic_nwrites",  32'(wrCount - wr0), 32'd4);
        checkOutput("basic_wa0", wrAddr[0], 32'h40);
        checkOutput("basic_wa1", wrAddr[1], 32'h44);
        checkOutput("basic_wa2", wrAddr[2], 32'h48);
        checkOutput("basic_wa3", wrAddr[3], 32'h4C);
        checkOutput("basic_d0", ram[16], 32'h11);
        checkOutput("basic_d1", ram[17], 32'h22);
        checkOutput("basic_d2", ram[18], 32'h33);
        checkOutput("basic_d3", ram[19], 32'h44);
        checkOutput("basic_no_err", 32'(errN), 32'd0);
        checkOutput("wdata_hold", mem_wdata, 32'h44);

        // Same transfer with gnt toggling: 7 stall cycles on top of 9
        $display("[TB] grant stalls");
        clearRam();
        ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[3] = 32'h44;
        wr0 = wrCount;
        applyStimulus(32'h00, 32'h40, 4);
        waitIdle(1'b1, 80, busyN, doneN, weV, errN);
        checkOutput("stall_we_gated", 32'(weV), 32'd0);
        checkOutput("stall_done_cyc", 32'(doneN), 32'd16);
        checkOutput("stall_busy_len", 32'(busyN), 32'd16);
        checkOutput("stall_nwrites",  32'(wrCount - wr0), 32'd4);
        checkOutput("stall_d0", ram[16], 32'h11);
        checkOutput("stall_d3", ram[19], 32'h44);

        // length = 0: done next cycle, no writes
        $display("[TB] zero length");
        wr0 = wrCount;
        applyStimulus(32'h00, 32'h40, 0);
        waitIdle(1'b0, 20, busyN, doneN, weV, errN);
        checkOutput("zero_done_cyc", 32'(doneN), 32'd1);
        checkOutput("zero_busy_len", 32'(busyN), 32'd1);
        checkOutput("zero_nwrites",  32'(wrCount - wr0), 32'd0);

        // Misaligned source: err pulse only
        $display("[TB] misaligned");
        wr0 = wrCount;
        applyStimulus(32'h02, 32'h40, 4);
        checkOutput("mis_err",  32'(err), 32'd1);
        checkOutput("mis_busy", 32'(busy), 32'd0);
        checkOutput("mis_done", 32'(done), 32'd0);
        tick();
        checkOutput("mis_err_pulse", 32'(err), 32'd0);
        checkOutput("mis_busy2", 32'(busy), 32'd0);
        checkOutput("mis_nwrites", 32'(wrCount - wr0), 32'd0);

        // Start while busy is ignored
        $display("[TB] start while busy");
        clearRam();
        ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[3] = 32'h44;
        ram[32] = 32'h55; ram[33] = 32'h66;
        wr0 = wrCount;
        applyStimulus(32'h00, 32'h40, 4);
        src_addr = 32'h80;
        dst_addr = 32'hC0;
        length   = LEN_W'(2);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        waitIdle(1'b0, 50, busyN, doneN, weV, errN);
        checkOutput("busy_start_done", 32'(doneN), 32'd7);
        checkOutput("busy_start_err",  32'(errN), 32'd0);
        checkOutput("busy_start_nwr",  32'(wrCount - wr0), 32'd4);
        checkOutput("busy_start_d3",   ram[19], 32'h44);
        checkOutput("busy_start_untouched", ram[48], 32'hDEAD0030);

        // Overlapping forward copy
        $display("[TB] overlap");
        clearRam();
        ram[0] = 32'd1; ram[1] = 32'd2; ram[2] = 32'd3; ram[3] = 32'd4;
        applyStimulus(32'h00, 32'h04, 3);
        waitIdle(1'b0, 50, busyN, doneN, weV, errN);
        checkOutput("ovl_w0", ram[0], 32'd1);
        checkOutput("ovl_w1", ram[1], 32'd1);
        checkOutput("ovl_w2", ram[2], 32'd1);
        checkOutput("ovl_w3", ram[3], 32'd1);

        // Reset during the WRITE of word 2
        $display("[TB] reset mid-op");
        clearRam();
        ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[3] = 32'h44;
        wr0 = wrCount;
        applyStimulus(32'h00, 32'h40, 4);
        tick();
        tick();
        tick();
        #2;
        checkOutput("mid_we_before",   32'(mem_we), 32'd1);
        checkOutput("mid_addr_before", mem_addr, 32'h44);
        reset = 1'b0;
        #1;
        checkOutput("mid_we_async",  32'(mem_we), 32'd0);
        checkOutput("mid_busy",      32'(busy), 32'd0);
        checkOutput("mid_addr",      mem_addr, 32'd0);
        checkOutput("mid_wdata",     mem_wdata, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("mid_nwrites", 32'(wrCount - wr0), 32'd1);
        checkOutput("mid_word1",   ram[16], 32'h11);
        checkOutput("mid_word2",   ram[17], 32'hDEAD0011);
        applyStimulus(32'h08, 32'h60, 1);
        waitIdle(1'b0, 20, busyN, doneN, weV, errN);
        checkOutput("post_rst_done", 32'(doneN), 32'd3);
        checkOutput("post_rst_data", ram[24], 32'h33);

        // Source address wraps past the top of the address space
        $display("[TB] wrap");
        clearRam();
        ram[63] = 32'hAAAA;
        ram[0]  = 32'hBBBB;
        applyStimulus(32'hFFFFFFFC, 32'h80, 2);
        checkOutput("wrap_rd1", mem_addr, 32'hFFFFFFFC);
        tick();
        checkOutput("wrap_wr1", mem_addr, 32'h80);
        tick();
        checkOutput("wrap_rd2", mem_addr, 32'h00000000);
        waitIdle(1'b0, 20, busyN, doneN, weV, errN);
        checkOutput("wrap_d0", ram[32], 32'hAAAA);
        checkOutput("wrap_d1", ram[33], 32'hBBBB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
